// File: rtl/rr_bus_mux.sv
// rr_bus_mux: NUM_CH-to-1 valid/ready mux, round-robin or fixed-priority, registered output.
// Optional RR_BUS_MUX_XFER_CNT_EN adds a 16-bit output handshake counter (xfer_cnt).
module rr_bus_mux #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int PRIO_MODE = 0,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
`ifdef RR_BUS_MUX_XFER_CNT_EN
  output logic [15:0]             xfer_cnt,
`endif
  input  logic                    out_ready
);

  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     base;
  logic [CH_W-1:0]     gidx;
  logic [CH_W-1:0]     nxt_ptr;
  logic [CH_W:0]       sum;
  logic [2*NUM_CH-1:0] rot;
  logic [NUM_CH-1:0]   grant;
  logic [WIDTH-1:0]    gdata;
  logic                any;
  logic                load;
  logic                xfer;

  assign base = (PRIO_MODE != 0) ? '0 : ptr;

  // Rotate so the search always starts at bit 0, then map back to a channel.
  always_comb begin
    rot  = {in_valid, in_valid} >> base;
    any  = 1'b0;
    sum  = '0;
    gidx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, base} + (CH_W+1)'(k);
      end
    end
    if (sum >= (CH_W+1)'(NUM_CH))
      sum = sum - (CH_W+1)'(NUM_CH);
    gidx = sum[CH_W-1:0];
  end

  always_comb begin
    grant = '0;
    gdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (any && gidx == CH_W'(i)) begin
        grant[i] = 1'b1;
        gdata    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = !out_valid | out_ready;
  assign in_ready = grant & {NUM_CH{load}};
  assign xfer     = any & load;
  assign nxt_ptr  = (gidx == CH_W'(NUM_CH-1)) ? '0
                  : gidx + CH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_ch    <= gidx;
      ptr       <= nxt_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_BUS_MUX_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (out_valid && out_ready)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rr_bus_mux.sv
// tb_rr_bus_mux: directed and randomized checks of rr_bus_mux
// against a behavioural arbitration model (RR and fixed-priority instances).
module tb_rr_bus_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  rr_in_ready;
  logic        rr_out_valid;
  logic [7:0]  rr_out_data;
  logic [1:0]  rr_out_ch;
  logic [3:0]  fp_in_ready;
  logic        fp_out_valid;
  logic [7:0]  fp_out_data;
  logic [1:0]  fp_out_ch;
`ifdef RR_BUS_MUX_XFER_CNT_EN
  logic [15:0] rr_cnt;
  logic [15:0] fp_cnt;
`endif

  int tests = 0;
  int fails = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;
  int         m_cnt;

  rr_bus_mux #(.NUM_CH(4), .WIDTH(8), .PRIO_MODE(0)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_ch    (rr_out_ch),
`ifdef RR_BUS_MUX_XFER_CNT_EN
    .xfer_cnt  (rr_cnt),
`endif
    .out_ready (out_ready)
  );

  rr_bus_mux #(.NUM_CH(4), .WIDTH(8), .PRIO_MODE(1)) u_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_ch    (fp_out_ch),
`ifdef RR_BUS_MUX_XFER_CNT_EN
    .xfer_cnt  (fp_cnt),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int arb(input logic [3:0] v, input int ptr,
                             input bit prio);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = prio ? k : (ptr + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int g;
    r = 4'b0000;
    if (m_valid && !out_ready) return r;
    g = arb(in_valid, m_ptr, 1'b0);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endfunction

  task automatic tick();
    int          g;
    bit          pop;
    logic [31:0] d;
    pop = m_valid && out_ready;
    g   = (m_valid && !out_ready) ? -1 : arb(in_valid, m_ptr, 1'b0);
    d   = in_data;
    @(posedge clk);
    if (pop) m_cnt = (m_cnt + 1) % 65536;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = d[g*8 +: 8];
      m_ch    = g;
      m_ptr   = (g + 1) % 4;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = 32'h4332_2110;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    tests++;
    if (rr_in_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_ready got %b want 0001", rr_in_ready);
    end
    tick();
    tick();
    tests++;
    if (rr_out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid got %b want 1", rr_out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00
        || rr_out_ch !== 2'd0) begin
      fails++;
      $display("FAIL async_reset got v=%b d=%h c=%0d want 0 00 0",
               rr_out_valid, rr_out_data, rr_out_ch);
    end
    tests++;
    if (fp_out_valid !== 1'b0 || fp_out_data !== 8'h00) begin
      fails++;
      $display("FAIL async_reset_fp got v=%b d=%h want 0 00",
               fp_out_valid, fp_out_data);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    tests++;
    if (rr_in_ready !== 4'b0001) begin
      fails++;
      $display("FAIL post_reset_ready got %b want 0001", rr_in_ready);
    end
    tick();
    tests++;
    if (rr_out_ch !== 2'd0 || rr_out_data !== 8'h10) begin
      fails++;
      $display("FAIL post_reset_grant got ch=%0d d=%h want 0 10",
               rr_out_ch, rr_out_data);
    end
  endtask

  task automatic test_rr_rotation();
    int         exp_c[4];
    logic [7:0] exp_d[4];
    exp_c = '{1, 2, 3, 0};
    exp_d = '{8'h21, 8'h32, 8'h43, 8'h10};
    in_valid  = 4'b1111;
    in_data   = 32'h4332_2110;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'(exp_c[c])
          || rr_out_data !== exp_d[c]) begin
        fails++;
        $display("FAIL rotation[%0d] got v=%b ch=%0d d=%h want 1 %0d %h",
                 c, rr_out_valid, rr_out_ch, rr_out_data,
                 exp_c[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_wrap_skip();
    int exp_c[3];
    exp_c = '{3, 0, 3};
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (rr_in_ready[2:1] !== 2'b00 || rr_in_ready !== exp_ready()) begin
        fails++;
        $display("FAIL skip_ready[%0d] got %b want %b",
                 c, rr_in_ready, exp_ready());
      end
      tick();
      tests++;
      if (rr_out_ch !== 2'(exp_c[c])) begin
        fails++;
        $display("FAIL wrap_ch[%0d] got %0d want %0d",
                 c, rr_out_ch, exp_c[c]);
      end
    end
  endtask

  task automatic test_back_pressure();
    in_valid  = 4'b0100;
    in_data   = 32'h4332_2110;
    out_ready = 1'b1;
    tick();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (rr_in_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall_ready[%0d] got %b want 0000", c, rr_in_ready);
      end
      tick();
      tests++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h32
          || rr_out_ch !== 2'd2) begin
        fails++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h ch=%0d want 1 32 2",
                 c, rr_out_valid, rr_out_data, rr_out_ch);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (rr_in_ready !== 4'b1000) begin
      fails++;
      $display("FAIL resume_ready got %b want 1000", rr_in_ready);
    end
    tick();
    tests++;
    if (rr_out_ch !== 2'd3 || rr_out_data !== 8'h43) begin
      fails++;
      $display("FAIL resume_load got ch=%0d d=%h want 3 43",
               rr_out_ch, rr_out_data);
    end
  endtask

  task automatic test_prio();
    in_valid  = 4'b1110;
    in_data   = 32'h4332_2110;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (fp_in_ready !== 4'b0010) begin
        fails++;
        $display("FAIL prio_ready[%0d] got %b want 0010", c, fp_in_ready);
      end
      tick();
      tests++;
      if (fp_out_ch !== 2'd1 || fp_out_data !== 8'h21) begin
        fails++;
        $display("FAIL prio_ch[%0d] got ch=%0d d=%h want 1 21",
                 c, fp_out_ch, fp_out_data);
      end
    end
    in_valid = 4'b1000;
    #1;
    tests++;
    if (fp_in_ready !== 4'b1000) begin
      fails++;
      $display("FAIL prio_ch3_ready got %b want 1000", fp_in_ready);
    end
    tick();
    tests++;
    if (fp_out_ch !== 2'd3 || fp_out_data !== 8'h43) begin
      fails++;
      $display("FAIL prio_ch3 got ch=%0d d=%h want 3 43",
               fp_out_ch, fp_out_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests++;
      if (rr_in_ready !== exp_ready()) begin
        fails++;
        $display("FAIL rand_ready[%0d] got %b want %b",
                 c, rr_in_ready, exp_ready());
      end
      tick();
      tests++;
      if (rr_out_valid !== m_valid || rr_out_data !== m_data
          || rr_out_ch !== 2'(m_ch)) begin
        fails++;
        $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want %b %h %0d",
                 c, rr_out_valid, rr_out_data, rr_out_ch,
                 m_valid, m_data, m_ch);
      end
`ifdef RR_BUS_MUX_XFER_CNT_EN
      tests++;
      if (rr_cnt !== 16'(m_cnt)) begin
        fails++;
        $display("FAIL rand_cnt[%0d] got %0d want %0d", c, rr_cnt, m_cnt);
      end
`endif
    end
  endtask

`ifdef RR_BUS_MUX_XFER_CNT_EN
  task automatic test_counter();
    int n;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    n = (65535 - m_cnt + 65536) % 65536;
    for (int c = 0; c < n; c++) tick();
    tests++;
    if (rr_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL cnt_preload got %h want ffff", rr_cnt);
    end
    out_ready = 1'b0;
    tick();
    tests++;
    if (rr_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL cnt_stall got %h want ffff", rr_cnt);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (rr_cnt !== 16'h0000) begin
      fails++;
      $display("FAIL cnt_wrap got %h want 0000", rr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_rotation();
    test_wrap_skip();
    test_back_pressure();
    test_prio();
    test_random();
`ifdef RR_BUS_MUX_XFER_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_bus_mux.md
Name: rr_bus_mux

Overview:
- Parametrised successor to the 2:1 select-bus mux.
- Merges NUM_CH input channels of WIDTH bits onto one output channel.
- Uses valid/ready handshakes, round-robin or fixed-priority arbitration, and a registered output stage.
- Sits between multiple producers and a single consumer bus.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- PRIO_MODE, 0, 0 = round-robin arbitration; 1 = fixed priority, lowest index wins.
- CH_W, derived localparam = clog2(NUM_CH), width of the channel-index fields.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_data  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel ready, combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data.
- out_ch  output  CH_W  source channel of out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer=0.
  - Transfer counter (if compiled in) = 0.
- Reset mid-transfer discards the held word; no replay after reset.
- Load enable: load = !out_valid | out_ready.
- Grant:
  - Computed combinationally from in_valid and the pointer.
  - Exactly one bit set when any in_valid is set; zero otherwise.
- Round-robin (PRIO_MODE=0):
  - Search starts at the pointer index and wraps NUM_CH-1 -> 0.
  - First valid channel found wins.
- Fixed priority (PRIO_MODE=1):
  - Lowest valid index wins.
  - Pointer is ignored but still updates.
- in_ready[i] = grant[i] & load. Every other channel's ready is 0. Ready never depends on that channel's own in_valid except through grant.
- Transfer on channel i: in_valid[i] & in_ready[i]. At that rising edge:
  - out_data <= channel i data; out_ch <= i; out_valid <= 1.
  - Pointer <= (i+1) mod NUM_CH; wraps from NUM_CH-1 to 0.
- Output handshake:
  - out_valid & out_ready with no new grant -> out_valid <= 0. out_data and out_ch hold their last values.
  - out_valid & !out_ready -> out_data and out_ch stay stable, and all in_ready = 0 (back-pressure).
  - Simultaneous out_ready and new grant -> pop and load in the same cycle. Sustained 1 word/cycle.
- Latency: input transfer to out_valid = 1 cycle.
- Pointer advances only on a transfer. An idle cycle or a stalled cycle leaves it unchanged.
- No in_valid set -> no grant, pointer holds.
- Dropping in_valid before handshake is legal; arbitration re-evaluates every cycle.
- Fairness: in RR mode, with all channels continuously valid, each channel is granted once per NUM_CH transfers.

Optional Feature:
- Macro: RR_BUS_MUX_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt [15:0], reset 0.
  - Increments by 1 on every output handshake (out_valid & out_ready).
  - Wraps 16'hFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset value check (NUM_CH=4, WIDTH=8): assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, before any clock edge; after release, first grant goes to channel 0 when in_valid=4'b1111.
- Round-robin rotation: in_valid=4'b1111 held, data ch0..3 = 8'h10, 8'h21, 8'h32, 8'h43, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data matches the source channel each time, one word per cycle.
- Wrap and skip: in_valid=4'b1001 after a channel-0 grant -> next out_ch=3, then 0, then 3; channels 1 and 2 never get in_ready.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1, out_data=8'h32 -> out_data and out_ch stable, in_ready=0, pointer unchanged; out_ready=1 -> next word loads the same cycle.
- Fixed priority (PRIO_MODE=1): in_valid=4'b1110 held -> out_ch=1 every cycle; channel 3 gets in_ready only once in_valid[2:1]=0.
- Counter (RR_BUS_MUX_XFER_CNT_EN defined): preload via 65535 handshakes, then one more -> xfer_cnt=0; a stalled cycle does not increment.
